// File: rtl/enemy_motion_if.sv
// Signal bundle between the entity interface/renderer and one enemy_motion engine.
// The master drives frame strobes, direction and spawn/hit requests; the slave returns position and status.
interface enemy_motion_if;
   logic       frame_tick;
   logic [1:0] dir;
   logic       spawn;
   logic [9:0] spawn_x;
   logic [9:0] spawn_y;
   logic       hit;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       active;
   logic       dying;
   logic       blocked;

   modport master (
      output frame_tick, dir, spawn, spawn_x, spawn_y, hit,
      input  pos_x, pos_y, active, dying, blocked
   );

   modport slave (
      input  frame_tick, dir, spawn, spawn_x, spawn_y, hit,
      output pos_x, pos_y, active, dying, blocked
   );
endinterface

// File: rtl/enemy_motion.sv
// Per-enemy movement engine: frame-paced stepping, playfield clamping, wall pause and death sequence.
// Optional feature macro: ENEMY_HP_EN (multi-hit enemies with a 2-bit hit-point register).
module enemy_motion #(
   parameter int STEP         = 2,
   parameter int MOVE_DIV     = 2,
   parameter int X_MIN        = 16,
   parameter int X_MAX        = 608,
   parameter int Y_MIN        = 16,
   parameter int Y_MAX        = 448,
   parameter int PAUSE_FRAMES = 30,
   parameter int DEATH_FRAMES = 20,
   parameter int HP_INIT      = 3
) (
   input logic           clk,
   input logic           reset,
   enemy_motion_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MOVE, BLOCKED, DYING} state_t;

   localparam int DIV_W   = $clog2(MOVE_DIV + 1);
   localparam int PAUSE_W = $clog2(PAUSE_FRAMES + 1);
   localparam int DEATH_W = $clog2(DEATH_FRAMES + 1);

   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] X_LO   = 11'(X_MIN);
   localparam logic signed [10:0] X_HI   = 11'(X_MAX);
   localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
   localparam logic signed [10:0] Y_HI   = 11'(Y_MAX);

   state_t               state, state_next;
   logic [DIV_W-1:0]     div_cnt, div_next;
   logic [PAUSE_W-1:0]   pause_cnt, pause_next;
   logic [DEATH_W-1:0]   death_cnt, death_next;
   logic [9:0]           pos_x, pos_y, x_next, y_next;
   logic                 active_q, dying_q, blocked_q;
   logic                 active_next, dying_next, blocked_next;
   logic                 hit_kill, hit_absorb;

   // Candidate step on the axis selected by dir; dir[1] picks X, dir[0] picks the positive direction.
   logic                 on_x;
   logic signed [10:0]   cur, cand, lo, hi, landed;
   logic                 wall;
   logic [9:0]           spawn_cx, spawn_cy;

   always_comb begin
      on_x   = bus.dir[1];
      cur    = on_x ? signed'({1'b0, pos_x}) : signed'({1'b0, pos_y});
      lo     = on_x ? X_LO : Y_LO;
      hi     = on_x ? X_HI : Y_HI;
      cand   = bus.dir[0] ? cur + STEP_S : cur - STEP_S;
      wall   = (cand < lo) || (cand > hi);
      landed = (cand < lo) ? lo : ((cand > hi) ? hi : cand);
   end

   always_comb begin
      spawn_cx = (bus.spawn_x < 10'(X_MIN)) ? 10'(X_MIN) :
                 (bus.spawn_x > 10'(X_MAX)) ? 10'(X_MAX) : bus.spawn_x;
      spawn_cy = (bus.spawn_y < 10'(Y_MIN)) ? 10'(Y_MIN) :
                 (bus.spawn_y > 10'(Y_MAX)) ? 10'(Y_MAX) : bus.spawn_y;
   end

`ifdef ENEMY_HP_EN
   logic [1:0] hp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hp <= 2'd0;
      else if (state == IDLE && bus.spawn)
         hp <= 2'(HP_INIT);
      else if ((state == MOVE || state == BLOCKED) && bus.hit && hp != 2'd0)
         hp <= hp - 2'd1;
   end

   assign hit_kill   = bus.hit && (hp <= 2'd1);
   assign hit_absorb = bus.hit && (hp > 2'd1);
`else
   assign hit_kill   = bus.hit;
   assign hit_absorb = 1'b0;
`endif

   // State register: FSM state, counters, position and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         pause_cnt <= '0;
         death_cnt <= '0;
         pos_x     <= '0;
         pos_y     <= '0;
         active_q  <= 1'b0;
         dying_q   <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
         state     <= state_next;
         div_cnt   <= div_next;
         pause_cnt <= pause_next;
         death_cnt <= death_next;
         pos_x     <= x_next;
         pos_y     <= y_next;
         active_q  <= active_next;
         dying_q   <= dying_next;
         blocked_q <= blocked_next;
      end
   end

   // Next-state logic; a hit outranks a same-cycle frame_tick.
   always_comb begin
      // NOTE: every target gets a hold default first so no path can infer a latch.
      state_next   = state;
      div_next     = div_cnt;
      pause_next   = pause_cnt;
      death_next   = death_cnt;
      x_next       = pos_x;
      y_next       = pos_y;
      blocked_next = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.spawn) begin
               x_next     = spawn_cx;
               y_next     = spawn_cy;
               div_next   = '0;
               state_next = MOVE;
            end
         end
         MOVE, BLOCKED: begin
            if (hit_kill) begin
               death_next = '0;
               state_next = DYING;
            end else if (hit_absorb) begin
               state_next = state;
            end else if (bus.frame_tick) begin
               if (state == MOVE) begin
                  if (div_cnt == DIV_W'(MOVE_DIV - 1)) begin
                     div_next = '0;
                     if (on_x) x_next = landed[9:0];
                     else      y_next = landed[9:0];
                     if (wall) begin
                        blocked_next = 1'b1;
                        pause_next   = '0;
                        state_next   = BLOCKED;
                     end
                  end else begin
                     div_next = div_cnt + 1'b1;
                  end
               end else if (pause_cnt == PAUSE_W'(PAUSE_FRAMES - 1)) begin
                  div_next   = '0;
                  state_next = MOVE;
               end else begin
                  pause_next = pause_cnt + 1'b1;
               end
            end
         end
         DYING: begin
            if (bus.frame_tick) begin
               if (death_cnt == DEATH_W'(DEATH_FRAMES - 1))
                  state_next = IDLE;
               else
                  death_next = death_cnt + 1'b1;
            end
         end
      endcase
   end

   // Output logic, decoded from the next state so the registered flags align with it.
   always_comb begin
      active_next = (state_next != IDLE);
      dying_next  = (state_next == DYING);
   end

   assign bus.pos_x   = pos_x;
   assign bus.pos_y   = pos_y;
   assign bus.active  = active_q;
   assign bus.dying   = dying_q;
   assign bus.blocked = blocked_q;

endmodule

// File: tb/tb_enemy_motion.sv
// Self-checking bench for enemy_motion: directed scenarios plus randomized traffic against a countdown model.
module tb_enemy_motion;

   localparam int STEP         = 2;
   localparam int MOVE_DIV     = 2;
   localparam int X_MIN        = 16;
   localparam int X_MAX        = 608;
   localparam int Y_MIN        = 16;
   localparam int Y_MAX        = 448;
   localparam int PAUSE_FRAMES = 30;
   localparam int DEATH_FRAMES = 20;

   logic clk = 1'b0;
   logic reset;
   enemy_motion_if bus ();

   enemy_motion dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: presence flags plus countdowns of frames remaining to each event.
   bit m_on, m_dying, m_paused, m_blk;
   int m_x, m_y, m_to_step, m_pause_left, m_death_left;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_reset();
      m_on = 0; m_dying = 0; m_paused = 0; m_blk = 0;
      m_x = 0; m_y = 0; m_to_step = MOVE_DIV; m_pause_left = 0; m_death_left = 0;
   endtask

   task automatic model_step(input bit sp, input int sx, input int sy,
                             input bit h, input bit t, input int d);
      int nx, ny;
      m_blk = 0;
      if (!m_on) begin
         if (sp) begin
            m_x = clampi(sx, X_MIN, X_MAX);
            m_y = clampi(sy, Y_MIN, Y_MAX);
            m_on = 1; m_paused = 0; m_to_step = MOVE_DIV;
         end
      end else if (m_dying) begin
         if (t) begin
            m_death_left--;
            if (m_death_left == 0) begin m_on = 0; m_dying = 0; end
         end
      end else if (h) begin
         m_dying = 1; m_paused = 0; m_death_left = DEATH_FRAMES;
      end else if (t) begin
         if (m_paused) begin
            m_pause_left--;
            if (m_pause_left == 0) begin m_paused = 0; m_to_step = MOVE_DIV; end
         end else begin
            m_to_step--;
            if (m_to_step == 0) begin
               m_to_step = MOVE_DIV;
               nx = m_x; ny = m_y;
               case (d)
                  0: ny = m_y - STEP;
                  1: ny = m_y + STEP;
                  2: nx = m_x - STEP;
                  default: nx = m_x + STEP;
               endcase
               if (nx < X_MIN || nx > X_MAX || ny < Y_MIN || ny > Y_MAX) begin
                  m_blk = 1; m_paused = 1; m_pause_left = PAUSE_FRAMES;
               end
               m_x = clampi(nx, X_MIN, X_MAX);
               m_y = clampi(ny, Y_MIN, Y_MAX);
            end
         end
      end
   endtask

   task automatic compare();
      check("pos_x",   32'(bus.pos_x),   32'(m_x));
      check("pos_y",   32'(bus.pos_y),   32'(m_y));
      check("active",  32'(bus.active),  32'(m_on));
      check("dying",   32'(bus.dying),   32'(m_dying));
      check("blocked", 32'(bus.blocked), 32'(m_blk));
   endtask

   task automatic do_cycle(input bit sp, input int sx, input int sy,
                           input bit h, input bit t, input int d);
      bus.spawn      = sp;
      bus.spawn_x    = 10'(sx);
      bus.spawn_y    = 10'(sy);
      bus.hit        = h;
      bus.frame_tick = t;
      bus.dir        = 2'(d);
      @(posedge clk);
      model_step(sp, sx, sy, h, t, d);
      #1;
      compare();
   endtask

   task automatic ticks(input int n, input int d);
      for (int i = 0; i < n; i++) begin
         do_cycle(0, 0, 0, 0, 1, d);
         do_cycle(0, 0, 0, 0, 0, (d + 1) % 4);
      end
   endtask

   initial begin
      bus.spawn = 0; bus.spawn_x = '0; bus.spawn_y = '0;
      bus.hit = 0; bus.frame_tick = 0; bus.dir = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare();
      reset = 1'b0;

      // Spawn and basic rightward motion
      do_cycle(1, 100, 200, 0, 0, 3);
      check("spawn_active", 32'(bus.active), 32'd1);
      check("spawn_x", 32'(bus.pos_x), 32'd100);
      ticks(4, 3);
      check("walk_x", 32'(bus.pos_x), 32'd104);
      check("walk_y", 32'(bus.pos_y), 32'd200);

      // Hit together with the step tick: no step, death sequence starts
      do_cycle(0, 0, 0, 0, 1, 3);
      do_cycle(0, 0, 0, 1, 1, 3);
      check("hit_nostep", 32'(bus.pos_x), 32'd104);
      check("hit_dying", 32'(bus.dying), 32'd1);
      ticks(DEATH_FRAMES, 0);
      check("dead_active", 32'(bus.active), 32'd0);
      check("dead_dying", 32'(bus.dying), 32'd0);

      // Clamped spawn against the right wall and the pause
      do_cycle(1, 612, 50, 0, 0, 3);
      check("clamp_x", 32'(bus.pos_x), 32'd608);
      do_cycle(0, 0, 0, 0, 1, 3);
      do_cycle(0, 0, 0, 0, 1, 3);
      check("wall_pulse", 32'(bus.blocked), 32'd1);
      check("wall_hold", 32'(bus.pos_x), 32'd608);
      do_cycle(0, 0, 0, 0, 0, 3);
      check("wall_pulse_end", 32'(bus.blocked), 32'd0);
      ticks(PAUSE_FRAMES - 1, 2);
      check("pause_frozen", 32'(bus.pos_x), 32'd608);
      ticks(1, 2);
      ticks(2, 2);
      check("resume_x", 32'(bus.pos_x), 32'd606);

      // Async reset in the middle of DYING
      do_cycle(0, 0, 0, 1, 0, 0);
      ticks(5, 1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare();
      @(posedge clk);
      #1 reset = 1'b0;
      compare();
      do_cycle(1, 300, 5, 0, 0, 0);
      check("respawn_active", 32'(bus.active), 32'd1);
      check("respawn_y", 32'(bus.pos_y), 32'(Y_MIN));

      // Randomized traffic
      for (int i = 0; i < 6000; i++) begin
         do_cycle(($urandom_range(9) == 0), int'($urandom_range(1023)), int'($urandom_range(1023)),
                  ($urandom_range(149) == 0), ($urandom_range(1) == 0), int'($urandom_range(3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
